// File: rtl/tick_countdown_timer.sv
// Run-time programmable prescaler producing a one-cycle tick, driving a loadable
// tick countdown with start/pause control and a one-cycle done pulse on expiry.
module tick_countdown_timer #(
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned DIV_DEFAULT = 26_999_999,
  parameter int unsigned SEC_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] div_value,
  input  logic [SEC_W-1:0] secs,
  input  logic             start,
  input  logic             pause,
  output logic             tick,
  output logic [SEC_W-1:0] secs_left,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [SEC_W-1:0] r_secs_left;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [SEC_W-1:0] w_secs_nxt;
  logic             w_tick_nxt;
  logic             w_done_nxt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next register values; start outranks pause and expiry
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_secs_nxt  = r_secs_left;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (start) begin
      w_div_nxt = div_value;
      w_cnt_nxt = '0;
      if (secs != '0) begin
        w_state_nxt = S_RUN;
        w_secs_nxt  = secs;
      end else begin
        w_state_nxt = S_IDLE;
        w_secs_nxt  = '0;
        w_done_nxt  = 1'b1;
      end
    end else begin
      case (r_state)
        S_RUN, S_PAUSE: begin
          if (pause) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_state_nxt = S_RUN;
            // Equality compare keeps the wrap exact even for an all-ones divisor
            if (r_cnt == r_div) begin
              w_cnt_nxt  = '0;
              w_tick_nxt = 1'b1;
              w_secs_nxt = r_secs_left - SEC_W'(1);
              if (r_secs_left <= SEC_W'(1)) begin
                w_secs_nxt  = '0;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_secs_nxt  = '0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_div       <= CNT_W'(DIV_DEFAULT);
      r_secs_left <= '0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_secs_left <= w_secs_nxt;
      r_tick      <= w_tick_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
    end
  end

  assign tick      = r_tick;
  assign secs_left = r_secs_left;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer: an elapsed-cycle arithmetic model checked
// every cycle, plus literal expectations at hand-computed cycles.
module tb_tick_countdown_timer;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned DIVD  = 6;
  localparam int unsigned SEC_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] div_value = '0;
  logic [SEC_W-1:0] secs = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             tick;
  logic [SEC_W-1:0] secs_left;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  int rc = 0;

  // Model: ticks happen when the count of un-paused running edges hits a multiple of D+1
  bit     m_active = 1'b0;
  bit     m_tick = 1'b0;
  bit     m_done = 1'b0;
  longint m_el = 0;
  longint m_d = 0;
  longint m_n = 0;
  longint m_left = 0;

  tick_countdown_timer #(.CNT_W(CNT_W), .DIV_DEFAULT(DIVD), .SEC_W(SEC_W)) dut (
    .clk(clk), .reset(reset), .div_value(div_value), .secs(secs),
    .start(start), .pause(pause), .tick(tick), .secs_left(secs_left),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_tick = 1'b0; m_done = 1'b0;
      m_el = 0; m_left = 0; m_n = 0;
    end else begin
      m_tick = 1'b0;
      m_done = 1'b0;
      if (start) begin
        m_d  = longint'(div_value);
        m_el = 0;
        if (secs != '0) begin
          m_active = 1'b1; m_n = longint'(secs); m_left = m_n;
        end else begin
          m_active = 1'b0; m_done = 1'b1; m_left = 0;
        end
      end else if (m_active && !pause) begin
        m_el++;
        if (m_el % (m_d + 1) == 0) begin
          m_tick = 1'b1;
          m_left = m_n - m_el / (m_d + 1);
          if (m_left == 0) begin
            m_done = 1'b1;
            m_active = 1'b0;
          end
        end
      end
    end
    #1;
    chk("model_tick", 64'(tick), 64'(m_tick));
    chk("model_done", 64'(done), 64'(m_done));
    chk("model_busy", 64'(busy), 64'(m_active));
    chk("model_secs_left", 64'(secs_left), 64'(m_left));
  end

  task automatic go_to(input int k);
    while (rc < k) begin
      @(negedge clk);
      rc++;
    end
  endtask

  task automatic do_start(input int d, input int n);
    div_value = CNT_W'(d);
    secs      = SEC_W'(n);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rc    = 0;
  endtask

  task automatic expect_out(input string nm, input logic t, input logic dn,
                            input logic b, input int sl);
    chk({nm, "_tick"}, 64'(tick), 64'(t));
    chk({nm, "_done"}, 64'(done), 64'(dn));
    chk({nm, "_busy"}, 64'(busy), 64'(b));
    chk({nm, "_secs"}, 64'(secs_left), 64'(sl));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    @(negedge clk);

    // D=2, N=3; input changes while busy must be ignored
    do_start(2, 3);
    expect_out("t1_c0", 1'b0, 1'b0, 1'b1, 3);
    div_value = CNT_W'(7); secs = SEC_W'(9);
    go_to(2);  expect_out("t1_c2", 1'b0, 1'b0, 1'b1, 3);
    go_to(3);  expect_out("t1_c3", 1'b1, 1'b0, 1'b1, 2);
    go_to(6);  expect_out("t1_c6", 1'b1, 1'b0, 1'b1, 1);
    go_to(9);  expect_out("t1_c9", 1'b1, 1'b1, 1'b0, 0);
    go_to(10); expect_out("t1_c10", 1'b0, 1'b0, 1'b0, 0);

    // D=0, N=4
    do_start(0, 4);
    go_to(1); expect_out("t2_c1", 1'b1, 1'b0, 1'b1, 3);
    go_to(4); expect_out("t2_c4", 1'b1, 1'b1, 1'b0, 0);
    go_to(6);

    // D=4, N=2 with pause sampled high on edges 2..4
    do_start(4, 2);
    go_to(1); pause = 1'b1;
    go_to(3); expect_out("t3_c3", 1'b0, 1'b0, 1'b1, 2);
    go_to(4); pause = 1'b0;
    go_to(7);  expect_out("t3_c7", 1'b0, 1'b0, 1'b1, 2);
    go_to(8);  expect_out("t3_c8", 1'b1, 1'b0, 1'b1, 1);
    go_to(12); expect_out("t3_c12", 1'b0, 1'b0, 1'b1, 1);
    go_to(13); expect_out("t3_c13", 1'b1, 1'b1, 1'b0, 0);
    go_to(15);

    // Restart mid-run: D=2,N=5 then at edge 4 D=1,N=1
    do_start(2, 5);
    go_to(3); expect_out("t4_c3", 1'b1, 1'b0, 1'b1, 4);
    div_value = CNT_W'(1); secs = SEC_W'(1); start = 1'b1;
    @(negedge clk); start = 1'b0; rc = 4;
    expect_out("t4_c4", 1'b0, 1'b0, 1'b1, 1);
    go_to(6); expect_out("t4_c6", 1'b1, 1'b1, 1'b0, 0);
    go_to(8);

    // N=0 start, then pause while idle
    do_start(3, 0);
    expect_out("t5_c0", 1'b0, 1'b1, 1'b0, 0);
    go_to(1); expect_out("t5_c1", 1'b0, 1'b0, 1'b0, 0);
    pause = 1'b1;
    go_to(4); expect_out("t5_pause_idle", 1'b0, 1'b0, 1'b0, 0);
    pause = 1'b0;

    // Async reset mid-run, then a run at the default divisor
    do_start(2, 3);
    go_to(4);
    #2 reset = 1'b1;
    #1 expect_out("t6_async", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(int'(DIVD), 1);
    go_to(6); expect_out("t6_c6", 1'b0, 1'b0, 1'b1, 1);
    go_to(7); expect_out("t6_c7", 1'b1, 1'b1, 1'b0, 0);
    go_to(8);

    // All-ones divisor wraps exactly
    do_start(31, 2);
    go_to(31); expect_out("t7_c31", 1'b0, 1'b0, 1'b1, 2);
    go_to(32); expect_out("t7_c32", 1'b1, 1'b0, 1'b1, 1);
    go_to(64); expect_out("t7_c64", 1'b1, 1'b1, 1'b0, 0);
    go_to(66);

    // Start outranks expiry and pause on the same edge
    do_start(0, 1);
    div_value = CNT_W'(1); secs = SEC_W'(2); start = 1'b1; pause = 1'b1;
    @(negedge clk); start = 1'b0; pause = 1'b0; rc = 1;
    expect_out("t8_c1", 1'b0, 1'b0, 1'b1, 2);
    go_to(3); expect_out("t8_c3", 1'b1, 1'b0, 1'b1, 1);
    go_to(5); expect_out("t8_c5", 1'b1, 1'b1, 1'b0, 0);
    go_to(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
